ofm_maxpool_rx: RTL and testbench
=================================

# ofm_maxpool_rx

Receive side of the convolution output stream. Accepts the 25 serial 36-bit OFM results (5x5 map, raster order) that the convolution engine emits on its out_valid/Out_OFM port, buffers the full map, then applies 2x2 max pooling with stride 1. The 16 pooled results (4x4 map) are streamed out serially in raster order. Sits directly downstream of the convolution engine in the lab datapath.

## Interface
Parameters:
- DW, 36, data width of OFM samples and pooled outputs
- N, 5, OFM edge length; the pooled map is (N-1)x(N-1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  OFM sample valid; driven by the convolution engine's out_valid
- In_OFM  in  DW  OFM sample, unsigned, raster order (row 0 col 0 first)
- busy  out  1  high in POOL state; upstream must not send
- overrun  out  1  one-cycle pulse: sample arrived while busy and was dropped
- out_valid  out  1  pooled sample valid
- Out_Pool  out  DW  pooled sample, unsigned; 0 whenever out_valid is low

## Operation
- States: IDLE, CAPTURE, POOL.
- IDLE: wr_cnt=0. in_valid high -> write In_OFM to buf[0], wr_cnt=1, go CAPTURE.
- CAPTURE: each cycle with in_valid high writes buf[wr_cnt], wr_cnt++. in_valid gaps of any length allowed; state holds, no timeout. Write of index N*N-1 -> go POOL, rd_r=rd_c=0.
- POOL: each cycle Out_Pool <= max(buf[r][c], buf[r][c+1], buf[r+1][c], buf[r+1][c+1]), out_valid <= 1. c increments 0..N-2, wraps to 0 with r++. After (r,c)=(N-2,N-2) -> go IDLE.
- Comparison unsigned, full DW bits; no truncation, no saturation. Equal operands: any, value identical.
- in_valid in POOL: sample dropped, buffer untouched, overrun pulses the next cycle. A new frame begins only once state is back in IDLE.
- Buffer is not cleared between frames; each frame fully overwrites it.

## Timing
- Reset values: out_valid=0, Out_Pool=0, busy=0, overrun=0, state=IDLE, wr_cnt=0, pool indices=0. Buffer contents need no reset.
- Reset has priority over all activity. Reset asserted mid-CAPTURE or mid-POOL abandons the frame: out_valid drops the cycle after reset, and no partial output follows.
- Let edge E capture the final (25th) sample. busy is high from E+1. out_valid is high for exactly 16 consecutive cycles, first registered at edge E+1 and last at E+16. state=IDLE and busy=0 from E+16. out_valid=0 from E+17.
- Earliest next-frame sample is accepted at edge E+16, when in_valid is high in the cycle state returns to IDLE. Back-to-back frames therefore need a ≥15-cycle gap. The convolution engine's inter-frame gap exceeds this.
- All outputs are registers, with no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding (IDLE/CAPTURE/POOL); localparams NSQ=N*N, PN=N-1, PNSQ=PN*PN; width of wr_cnt = $clog2(NSQ).
- One natural sub-module: max4 (combinational, DW-wide unsigned 4-input max as a 2-level compare tree). Instantiated once; everything else lives in the top.

## Test plan
- Ramp: In_OFM=0..24 contiguous -> 16 outputs 5r+c+6 for r,c in 0..3 (6,7,8,9,11,...,24). out_valid high exactly 16 cycles, starting 1 cycle after the last input.
- Reverse ramp 24..0 with random 0–3 cycle in_valid gaps -> outputs 24-(5r+c) (24,23,22,21,19,...,6). Gaps do not change values or the latency from the last sample.
- Extremes: all samples 0 except buf[12]=2^36-1 -> outputs at (1,1),(1,2),(2,1),(2,2) equal 2^36-1, all others 0. Verifies full-width unsigned compare.
- Overrun: send 25 samples, then a 26th at edge E+3 -> overrun pulses once. Pooled output is unchanged. The sample is not captured into the next frame.
- Reset mid-POOL: assert rst at the 5th pooled output -> out_valid=0, Out_Pool=0, busy=0 from the next cycle. A following clean ramp frame yields the correct ramp results.
- Back-to-back: two ramp frames separated by the minimum legal gap -> 32 correct outputs, no overrun.

Source files
------------

// File: rtl/ofm_maxpool_rx_pkg.sv
// ofm_maxpool_rx_pkg
//   Shared definitions for the OFM max-pool receiver: the receiver FSM
//   state encoding and the default map geometry.
//   No ports (package).
package ofm_maxpool_rx_pkg;

    localparam int unsigned OFM_DW   = 36;
    localparam int unsigned OFM_N    = 5;
    localparam int unsigned NSQ      = OFM_N * OFM_N;
    localparam int unsigned PN       = OFM_N - 1;
    localparam int unsigned PNSQ     = PN * PN;
    localparam int unsigned WR_CNT_W = $clog2(NSQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POOL    = 2'd2
    } state_t;

endpackage

// File: rtl/ofm_maxpool_rx_max4.sv
// ofm_maxpool_rx_max4
//   Combinational unsigned maximum of four DW-bit operands, built as a
//   two-level compare tree.
//   Ports:
//     i_a, i_b, i_c, i_d  in  DW  operands (unsigned)
//     o_max               out DW  largest operand
module ofm_maxpool_rx_max4 #(
    parameter int unsigned DW = 36
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_c,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_max
);

    logic [DW-1:0] w_ab;
    logic [DW-1:0] w_cd;

    always_comb begin
        w_ab  = (i_a >= i_b) ? i_a : i_b;
        w_cd  = (i_c >= i_d) ? i_c : i_d;
        o_max = (w_ab >= w_cd) ? w_ab : w_cd;
    end

endmodule

// File: rtl/ofm_maxpool_rx.sv
// ofm_maxpool_rx
//   Receives an NxN OFM map serially (raster order), buffers it, then
//   streams the (N-1)x(N-1) result of 2x2 / stride-1 max pooling, one
//   pooled sample per cycle, in raster order.
//   Ports:
//     clk        in   1   clock, rising edge
//     rst        in   1   synchronous active-high reset
//     in_valid   in   1   OFM sample valid
//     In_OFM     in   DW  OFM sample (unsigned)
//     busy       out  1   pooling in progress; upstream must hold off
//     overrun    out  1   one-cycle pulse: a sample was dropped while pooling
//     out_valid  out  1   pooled sample valid
//     Out_Pool   out  DW  pooled sample, 0 when out_valid is low
module ofm_maxpool_rx
    import ofm_maxpool_rx_pkg::*;
#(
    parameter int unsigned DW = OFM_DW,
    parameter int unsigned N  = OFM_N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] In_OFM,
    output logic          busy,
    output logic          overrun,
    output logic          out_valid,
    output logic [DW-1:0] Out_Pool
);

    localparam int unsigned L_NSQ   = N * N;
    localparam int unsigned L_PN    = N - 1;
    localparam int unsigned L_WR_W  = $clog2(L_NSQ);
    localparam int unsigned L_IDX_W = $clog2(N);

    state_t              r_state, w_state_nxt;
    logic [L_WR_W-1:0]   r_wr_cnt, w_wr_cnt_nxt;
    logic [L_IDX_W-1:0]  r_rd_r, r_rd_c, w_rd_r_nxt, w_rd_c_nxt;
    logic                w_wr_en;
    logic [L_WR_W-1:0]   w_wr_addr;
    logic                w_pool_last;
    logic                w_drop;
    logic [L_WR_W-1:0]   w_base;
    logic [DW-1:0]       w_max;
    logic [DW-1:0]       r_buf [L_NSQ];
    logic                r_busy, r_overrun, r_out_valid;
    logic [DW-1:0]       r_out_pool;

    assign w_pool_last = (r_rd_r == L_IDX_W'(L_PN - 1)) && (r_rd_c == L_IDX_W'(L_PN - 1));
    assign w_base      = L_WR_W'(r_rd_r) * L_WR_W'(N) + L_WR_W'(r_rd_c);

    ofm_maxpool_rx_max4 #(.DW(DW)) u_max4 (
        .i_a   (r_buf[w_base]),
        .i_b   (r_buf[w_base + L_WR_W'(1)]),
        .i_c   (r_buf[w_base + L_WR_W'(N)]),
        .i_d   (r_buf[w_base + L_WR_W'(N + 1)]),
        .o_max (w_max)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_r_nxt   = r_rd_r;
        w_rd_c_nxt   = r_rd_c;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_cnt;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_cnt_nxt = '0;
                if (in_valid) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = '0;
                    w_wr_cnt_nxt = L_WR_W'(1);
                    w_state_nxt  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    if (r_wr_cnt == L_WR_W'(L_NSQ - 1)) begin
                        w_wr_cnt_nxt = '0;
                        w_rd_r_nxt   = '0;
                        w_rd_c_nxt   = '0;
                        w_state_nxt  = S_POOL;
                    end else begin
                        w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                    end
                end
            end
            S_POOL: begin
                if (w_pool_last) begin
                    w_rd_r_nxt  = '0;
                    w_rd_c_nxt  = '0;
                    w_state_nxt = S_IDLE;
                    // The last pooled window never reads buf[0], so a sample
                    // arriving in this final cycle is taken as the start of
                    // the next frame rather than dropped.
                    if (in_valid) begin
                        w_wr_en      = 1'b1;
                        w_wr_addr    = '0;
                        w_wr_cnt_nxt = L_WR_W'(1);
                        w_state_nxt  = S_CAPTURE;
                    end
                end else begin
                    w_drop = in_valid;
                    if (r_rd_c == L_IDX_W'(L_PN - 1)) begin
                        w_rd_c_nxt = '0;
                        w_rd_r_nxt = r_rd_r + 1'b1;
                    end else begin
                        w_rd_c_nxt = r_rd_c + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_cnt    <= '0;
            r_rd_r      <= '0;
            r_rd_c      <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pool  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_rd_r      <= w_rd_r_nxt;
            r_rd_c      <= w_rd_c_nxt;
            r_busy      <= (r_state == S_POOL) && !w_pool_last;
            r_overrun   <= w_drop;
            r_out_valid <= (r_state == S_POOL);
            r_out_pool  <= (r_state == S_POOL) ? w_max : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_buf[w_wr_addr] <= In_OFM;
        end
    end

    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign out_valid = r_out_valid;
    assign Out_Pool  = r_out_pool;

endmodule

// File: tb/tb_ofm_maxpool_rx.sv
module tb_ofm_maxpool_rx;
    import ofm_maxpool_rx_pkg::*;

    localparam int unsigned DW = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] In_OFM;
    logic          busy;
    logic          overrun;
    logic          out_valid;
    logic [DW-1:0] Out_Pool;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [DW-1:0] frm      [NSQ];
    logic [DW-1:0] frm_next [NSQ];
    logic [DW-1:0] expv     [PNSQ];

    ofm_maxpool_rx #(.DW(DW), .N(OFM_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .In_OFM    (In_OFM),
        .busy      (busy),
        .overrun   (overrun),
        .out_valid (out_valid),
        .Out_Pool  (Out_Pool)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: each pooled value is the largest of the 2x2 window of the map.
    function automatic void build_expected();
        for (int unsigned r = 0; r < PN; r++) begin
            for (int unsigned c = 0; c < PN; c++) begin
                logic [DW-1:0] m;
                m = 0;
                for (int unsigned dr = 0; dr < 2; dr++)
                    for (int unsigned dc = 0; dc < 2; dc++)
                        if (frm[(r + dr) * OFM_N + c + dc] > m)
                            m = frm[(r + dr) * OFM_N + c + dc];
                expv[r * PN + c] = m;
            end
        end
    endfunction

    function automatic logic [DW-1:0] rand_word(input int unsigned bits);
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        if (bits < 64) t = t & ((64'd1 << bits) - 64'd1);
        return t[DW-1:0];
    endfunction

    task automatic run_frame(input string name, input int unsigned gap_max, input int unsigned first_idx,
                             input bit chain, input bit ovr, input bit rst_mid);
        build_expected();
        for (int unsigned i = first_idx; i < NSQ; i++) begin
            if (i > first_idx && gap_max > 0) begin
                int unsigned g;
                g = $urandom_range(gap_max, 0);
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            In_OFM   = frm[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        In_OFM   = '0;
        chk({name, ":valid_before_first"}, out_valid, 0);
        chk({name, ":busy_before_first"}, busy, 0);
        for (int unsigned k = 0; k < PNSQ; k++) begin
            @(negedge clk);
            chk($sformatf("%s:valid[%0d]", name, k), out_valid, 1);
            chk($sformatf("%s:pool[%0d]", name, k), Out_Pool, expv[k]);
            chk($sformatf("%s:busy[%0d]", name, k), busy, (k < PNSQ - 1) ? 1 : 0);
            chk($sformatf("%s:overrun[%0d]", name, k), overrun, (ovr && k == 2) ? 1 : 0);
            in_valid = 1'b0;
            if (ovr && k == 1) begin
                in_valid = 1'b1;
                In_OFM   = rand_word(DW);
            end
            if (chain && k == PNSQ - 2) begin
                in_valid = 1'b1;
                In_OFM   = frm_next[0];
            end
            if (chain && k == PNSQ - 1) begin
                in_valid = 1'b1;
                In_OFM   = frm_next[1];
            end
            if (rst_mid && k == 4) begin
                rst = 1'b1;
                @(negedge clk);
                chk({name, ":rst_valid"}, out_valid, 0);
                chk({name, ":rst_pool"}, Out_Pool, 0);
                chk({name, ":rst_busy"}, busy, 0);
                rst = 1'b0;
                for (int unsigned q = 0; q < 20; q++) begin
                    @(negedge clk);
                    chk($sformatf("%s:post_rst_valid[%0d]", name, q), out_valid, 0);
                end
                return;
            end
        end
        if (!chain) begin
            @(negedge clk);
            chk({name, ":valid_after_last"}, out_valid, 0);
            chk({name, ":pool_after_last"}, Out_Pool, 0);
            chk({name, ":busy_after_last"}, busy, 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        In_OFM   = '0;
        repeat (3) @(negedge clk);
        chk("reset:valid", out_valid, 0);
        chk("reset:pool", Out_Pool, 0);
        chk("reset:busy", busy, 0);
        chk("reset:overrun", overrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int unsigned i = 0; i < NSQ; i++) frm[i] = DW'(i);
        run_frame("ramp", 0, 0, 1'b0, 1'b0, 1'b0);

        for (int unsigned i = 0; i < NSQ; i++) frm[i] = DW'(NSQ - 1 - i);
        run_frame("reverse_gaps", 3, 0, 1'b0, 1'b0, 1'b0);

        for (int unsigned i = 0; i < NSQ; i++) frm[i] = '0;
        frm[12] = '1;
        run_frame("extreme", 0, 0, 1'b0, 1'b0, 1'b0);

        for (int unsigned i = 0; i < NSQ; i++) frm[i] = rand_word(DW);
        run_frame("overrun", 0, 0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        for (int unsigned i = 0; i < NSQ; i++) frm[i] = rand_word(DW);
        run_frame("after_overrun", 2, 0, 1'b0, 1'b0, 1'b0);

        for (int unsigned i = 0; i < NSQ; i++) frm[i] = rand_word(DW);
        run_frame("reset_mid_pool", 0, 0, 1'b0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < NSQ; i++) frm[i] = DW'(i);
        run_frame("ramp_after_reset", 0, 0, 1'b0, 1'b0, 1'b0);

        for (int unsigned i = 0; i < NSQ; i++) begin
            frm[i]      = DW'(i);
            frm_next[i] = DW'(i);
        end
        run_frame("b2b_first", 0, 0, 1'b1, 1'b0, 1'b0);
        for (int unsigned i = 0; i < NSQ; i++) frm[i] = frm_next[i];
        run_frame("b2b_second", 0, 2, 1'b0, 1'b0, 1'b0);

        for (int unsigned f = 0; f < 4; f++) begin
            for (int unsigned i = 0; i < NSQ; i++)
                frm[i] = (f % 2 == 0) ? rand_word(3) : rand_word(DW);
            repeat ($urandom_range(4, 0)) @(negedge clk);
            run_frame($sformatf("random%0d", f), 3, 0, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
